// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: the hex glyph table, the segment bit
// order and the helper that converts an active-high level to a pin level.
package seg7_pkg;

  localparam int SEG_W = 7;
  localparam int SEG_A = 0;
  localparam int SEG_G = 6;

  // Glyphs for hex 0..F, bit order {g,f,e,d,c,b,a}, 1 = segment lit.
  localparam logic [SEG_W-1:0] SEG_TABLE [16] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
    7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
    7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
    7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
  };

  function automatic logic pin_level(input logic lvl, input logic active_low);
    return lvl ^ active_low;
  endfunction

endpackage

// File: rtl/decseg7.sv
// Combinational hex-to-seven-segment decoder; output is active-high {g..a}.
module decseg7
  import seg7_pkg::*;
(
  input  logic [3:0]       hex,
  output logic [SEG_W-1:0] seg
);

  always_comb begin
    seg = SEG_TABLE[hex];
  end

endmodule

// File: rtl/decseg7_scan.sv
// Time-multiplexed hex display driver: shadows a display word, scans one
// digit per DIV clocks and drives registered seg/dp/an with optional blanking.
module decseg7_scan
  import seg7_pkg::*;
#(
  parameter int N_DIGITS   = 4,
  parameter int DIV        = 50000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] data,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic                  blank_lz,
  output logic [SEG_W-1:0]      seg,
  output logic                  dp,
  output logic [N_DIGITS-1:0]   an,
  output logic                  frame
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(N_DIGITS - 1);
  localparam logic          PIN_OFF    = ACTIVE_LOW;

  logic [PW-1:0]           presc_q, presc_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [4*N_DIGITS-1:0]   data_q, data_d;
  logic [N_DIGITS-1:0]     dpr_q, dpr_d;
  logic                    blz_q, blz_d;
  logic [SEG_W-1:0]        seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [N_DIGITS-1:0]     an_q, an_d;
  logic                    frame_q, frame_d;

  logic [3:0]              nib [N_DIGITS];
  logic [N_DIGITS-1:0]     blank_mask;
  logic                    zero_run;
  logic [3:0]              cur_nib;
  logic                    cur_blank;
  logic [SEG_W-1:0]        cur_seg;
  logic [SEG_W-1:0]        seg_lvl;
  logic                    dp_lvl;
  logic [N_DIGITS-1:0]     an_lvl;

  genvar gi;
  generate
    for (gi = 0; gi < N_DIGITS; gi++) begin : g_nib
      assign nib[gi] = data_q[4*gi +: 4];
    end
  endgenerate

  // Walk down from the most significant digit; a digit blanks only while every
  // nibble at or above it is zero. Digit 0 is excluded so zero still shows "0".
  always_comb begin
    blank_mask = '0;
    zero_run   = 1'b1;
    for (int i = N_DIGITS - 1; i >= 1; i--) begin
      zero_run      = zero_run & (nib[i] == 4'h0);
      blank_mask[i] = blz_q & zero_run & ~dpr_q[i];
    end
  end

  assign cur_nib   = nib[idx_q];
  assign cur_blank = blank_mask[idx_q];

  decseg7 u_decseg7 (
    .hex (cur_nib),
    .seg (cur_seg)
  );

  always_comb begin
    presc_d = presc_q + 1'b1;
    idx_d   = idx_q;
    frame_d = 1'b0;
    if (presc_q == PRESC_LAST) begin
      presc_d = '0;
      if (idx_q == IDX_LAST) begin
        idx_d   = '0;
        frame_d = 1'b1;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end

    data_d = data_q;
    dpr_d  = dpr_q;
    blz_d  = blz_q;
    if (load) begin
      data_d = data;
      dpr_d  = dp_in;
      blz_d  = blank_lz;
    end

    seg_lvl = '0;
    dp_lvl  = 1'b0;
    an_lvl  = '0;
    if (!cur_blank) begin
      seg_lvl       = cur_seg;
      dp_lvl        = dpr_q[idx_q];
      an_lvl[idx_q] = 1'b1;
    end

    seg_d = '0;
    for (int i = SEG_A; i <= SEG_G; i++) begin
      seg_d[i] = pin_level(seg_lvl[i], ACTIVE_LOW);
    end
    dp_d = pin_level(dp_lvl, ACTIVE_LOW);
    an_d = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      an_d[i] = pin_level(an_lvl[i], ACTIVE_LOW);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      dpr_q   <= '0;
      blz_q   <= 1'b0;
      frame_q <= 1'b0;
      seg_q   <= {SEG_W{PIN_OFF}};
      dp_q    <= PIN_OFF;
      an_q    <= {N_DIGITS{PIN_OFF}};
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      dpr_q   <= dpr_d;
      blz_q   <= blz_d;
      frame_q <= frame_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      an_q    <= an_d;
    end
  end

  assign seg   = seg_q;
  assign dp    = dp_q;
  assign an    = an_q;
  assign frame = frame_q;

endmodule

// File: tb/tb_decseg7_scan.sv
// Scoreboard bench for decseg7_scan: an active-high and an active-low instance
// share stimulus; directed expectations are queued per cycle and checked by a monitor.
module tb_decseg7_scan;

  localparam logic [6:0] P0 = 7'b0111111;
  localparam logic [6:0] P1 = 7'b0000110;
  localparam logic [6:0] P2 = 7'b1011011;
  localparam logic [6:0] P3 = 7'b1001111;
  localparam logic [6:0] P4 = 7'b1100110;
  localparam logic [6:0] P5 = 7'b1101101;
  localparam logic [6:0] P7 = 7'b0000111;
  localparam logic [6:0] PF = 7'b1110001;
  localparam logic [6:0] SCAN_PAT [4] = '{P4, P3, P2, P1};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic        blank_lz = 1'b0;
  logic [15:0] data = '0;
  logic [3:0]  dp_in = '0;

  logic [6:0]  seg0, seg1;
  logic        dp0, dp1, frame0, frame1;
  logic [3:0]  an0, an1;

  decseg7_scan #(.N_DIGITS(4), .DIV(4), .ACTIVE_LOW(1'b0)) u_dut_hi (
    .clk(clk), .rst(rst), .load(load), .data(data), .dp_in(dp_in),
    .blank_lz(blank_lz), .seg(seg0), .dp(dp0), .an(an0), .frame(frame0)
  );

  decseg7_scan #(.N_DIGITS(4), .DIV(4), .ACTIVE_LOW(1'b1)) u_dut_lo (
    .clk(clk), .rst(rst), .load(load), .data(data), .dp_in(dp_in),
    .blank_lz(blank_lz), .seg(seg1), .dp(dp1), .an(an1), .frame(frame1)
  );

  typedef struct {
    int         at;
    int         dut;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame;
    string      name;
  } exp_t;

  exp_t sbq[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Expectations are written active-high; the active-low instance sees the inverse pins.
  function automatic void push_both(input int at, input string name, input logic [3:0] a,
                                    input logic [6:0] s, input logic d, input logic f);
    exp_t e;
    e.at = at; e.dut = 0; e.an = a; e.seg = s; e.dp = d; e.frame = f; e.name = name;
    sbq.push_back(e);
    e.dut = 1; e.an = ~a; e.seg = ~s; e.dp = ~d;
    sbq.push_back(e);
  endfunction

  exp_t       mon_e;
  logic [3:0] got_an;
  logic [6:0] got_seg;
  logic       got_dp, got_fr;

  always @(negedge clk) begin
    while (sbq.size() > 0 && sbq[0].at <= cyc) begin
      mon_e   = sbq.pop_front();
      got_an  = (mon_e.dut == 0) ? an0 : an1;
      got_seg = (mon_e.dut == 0) ? seg0 : seg1;
      got_dp  = (mon_e.dut == 0) ? dp0 : dp1;
      got_fr  = (mon_e.dut == 0) ? frame0 : frame1;
      n_tests++;
      if (mon_e.at < cyc) begin
        n_fail++;
        $display("FAIL %s dut%0d: check for cycle %0d reached late at cycle %0d",
                 mon_e.name, mon_e.dut, mon_e.at, cyc);
      end else if ({got_an, got_seg, got_dp, got_fr} !==
                   {mon_e.an, mon_e.seg, mon_e.dp, mon_e.frame}) begin
        n_fail++;
        $display("FAIL %s dut%0d cyc %0d: got an=%b seg=%b dp=%b frame=%b, want an=%b seg=%b dp=%b frame=%b",
                 mon_e.name, mon_e.dut, cyc, got_an, got_seg, got_dp, got_fr,
                 mon_e.an, mon_e.seg, mon_e.dp, mon_e.frame);
      end else begin
        $display("[TB] ok %s dut%0d cyc %0d an=%b seg=%b dp=%b frame=%b",
                 mon_e.name, mon_e.dut, cyc, got_an, got_seg, got_dp, got_fr);
      end
    end
  end

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Resets both instances, checks the held-reset pins, then releases reset with a
  // load pending; r is the first cycle whose pins reflect post-reset state.
  task automatic begin_scene(input logic [15:0] d, input logic [3:0] dpv,
                             input logic bl, output int r);
    @(negedge clk);
    rst  = 1'b1;
    load = 1'b0;
    push_both(cyc + 2, "reset_hold", 4'b0000, 7'b0000000, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0; load = 1'b1; data = d; dp_in = dpv; blank_lz = bl;
    r = cyc + 1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    logic [3:0] a;
    logic [6:0] s;
    logic       d;

    // Plain scan of 1234
    begin_scene(16'h1234, 4'b0000, 1'b0, r);
    for (int t = 0; t < 36; t++)
      push_both(r + t, "scan", 4'(1 << ((t / 4) % 4)),
                (t == 0) ? P0 : SCAN_PAT[(t / 4) % 4], 1'b0, (t % 16) == 15);
    @(negedge clk); load = 1'b0;
    wait_until(r + 36);

    // Leading-zero blanking of 0070
    begin_scene(16'h0070, 4'b0000, 1'b1, r);
    for (int t = 0; t < 16; t++) begin
      case (t / 4)
        0:       begin a = 4'b0001; s = P0; end
        1:       begin a = 4'b0010; s = P7; end
        default: begin a = 4'b0000; s = 7'b0000000; end
      endcase
      push_both(r + t, "blank", a, s, 1'b0, t == 15);
    end
    @(negedge clk); load = 1'b0;
    wait_until(r + 16);

    // Decimal point keeps digit 2 lit
    begin_scene(16'h0005, 4'b0100, 1'b1, r);
    for (int t = 0; t < 16; t++) begin
      if (t / 4 == 1) continue;
      case (t / 4)
        0:       begin a = 4'b0001; s = (t == 0) ? P0 : P5; d = 1'b0; end
        2:       begin a = 4'b0100; s = P0; d = 1'b1; end
        default: begin a = 4'b0000; s = 7'b0000000; d = 1'b0; end
      endcase
      push_both(r + t, "dp_override", a, s, d, t == 15);
    end
    @(negedge clk); load = 1'b0;
    wait_until(r + 16);

    // Load FFFF in the middle of digit 1's slot
    begin_scene(16'h1234, 4'b0000, 1'b0, r);
    for (int t = 0; t < 12; t++) begin
      if (t == 0)     begin a = 4'b0001; s = P0; end
      else if (t < 4) begin a = 4'b0001; s = P4; end
      else if (t < 6) begin a = 4'b0010; s = P3; end
      else if (t < 8) begin a = 4'b0010; s = PF; end
      else            begin a = 4'b0100; s = PF; end
      push_both(r + t, "midslot_load", a, s, 1'b0, 1'b0);
    end
    @(negedge clk); load = 1'b0;
    wait_until(r + 4);
    load = 1'b1; data = 16'hFFFF;
    @(negedge clk); load = 1'b0;
    wait_until(r + 12);

    // Reset during digit 2; load during reset must be ignored
    begin_scene(16'h1234, 4'b0000, 1'b0, r);
    for (int t = 0; t < 20; t++) begin
      d = 1'b0;
      if (t == 0)       begin a = 4'b0001; s = P0; end
      else if (t < 10)  begin a = 4'(1 << (t / 4)); s = SCAN_PAT[t / 4]; end
      else if (t < 12)  begin a = 4'b0000; s = 7'b0000000; end
      else if (t < 16)  begin a = 4'b0001; s = P0; end
      else              begin a = 4'b0010; s = P0; end
      push_both(r + t, (t < 10) ? "pre_reset" : (t < 12) ? "reset_mid" : "post_reset",
                a, s, d, 1'b0);
    end
    @(negedge clk); load = 1'b0;
    wait_until(r + 9);
    rst = 1'b1; load = 1'b1; data = 16'hFFFF;
    wait_until(r + 11);
    rst = 1'b0; load = 1'b0;
    wait_until(r + 20);

    @(negedge clk);
    if (sbq.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d expectations left unchecked, want 0", sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/decseg7_scan.md
DECSEG7_SCAN -- requirements
Module: decseg7_scan

Interface
REQ-001 Parameter N_DIGITS, default 4, number of multiplexed digits (1..8).
REQ-002 Parameter DIV, default 50000, clk cycles each digit is displayed (>=2).
REQ-003 Parameter ACTIVE_LOW, default 1, 1 inverts seg, dp and an at the pins.
REQ-004 Port clk  input  1  sole clock; all state changes on rising edge.
REQ-005 Port rst  input  1  synchronous, active-high reset.
REQ-006 Port load  input  1  capture data, dp_in and blank_lz this cycle.
REQ-007 Port data  input  4*N_DIGITS  hex nibbles; nibble i is digit i; digit 0 is least significant.
REQ-008 Port dp_in  input  N_DIGITS  decimal-point request per digit.
REQ-009 Port blank_lz  input  1  mode: 1 enables leading-zero blanking.
REQ-010 Port seg  output  7  {g,f,e,d,c,b,a} segment drive.
REQ-011 Port dp  output  1  decimal-point drive.
REQ-012 Port an  output  N_DIGITS  one-hot digit enable.
REQ-013 Port frame  output  1  one-cycle pulse when the scan wraps to digit 0.

Function
REQ-014 Shadow registers for data, dp_in and blank_lz SHALL load on any cycle with load=1 and rst=0; load held high reloads every cycle.
REQ-015 Prescaler SHALL count 0..DIV-1; at DIV-1 it returns to 0 and digit index advances by 1.
REQ-016 Digit index SHALL wrap from N_DIGITS-1 to 0; frame SHALL pulse in the cycle after that wrap.
REQ-017 seg, dp and an SHALL be registered and reflect index and shadow contents with exactly 1 cycle latency; a load SHALL be visible on the pins 2 cycles after load is sampled.
REQ-018 Segment patterns (active-high, g..a), hex 0-F: 0111111, 0000110, 1011011, 1001111, 1100110, 1101101, 1111101, 0000111, 1111111, 1101111, 1110111, 1111100, 0111001, 1011110, 1111001, 1110001.
REQ-019 Digit i is blanked when blank_lz=1, i>0, every nibble at positions >=i is 0, and dp bit i is 0.
REQ-020 A blanked digit SHALL drive seg, dp and an inactive for its whole slot; the prescaler and index keep running.
REQ-021 Digit 0 SHALL never be blanked; all-zero data with blank_lz=1 displays a single "0".
REQ-022 An active an SHALL have exactly one bit set; an inactive an has none set.
REQ-023 The pin level of each active bit is 0 when ACTIVE_LOW=1 and 1 when ACTIVE_LOW=0; inactive is the opposite level.
REQ-024 A load in mid-slot SHALL change the displayed pattern without restarting the prescaler or the index.

Reset
REQ-025 rst=1 SHALL clear the prescaler, the index and all shadow registers to 0, and SHALL set frame to 0.
REQ-026 While rst=1, seg, dp and an SHALL be held at their inactive levels, and load SHALL be ignored.
REQ-027 On the first cycle after rst falls, the outputs SHALL show digit 0 with value 0 (an[0] active, pattern 0111111).
REQ-028 rst asserted mid-slot SHALL abort the scan; after release, scanning restarts at digit 0 with a full DIV-cycle slot.

Structure
REQ-029 A package seg7_pkg SHALL hold the 16-entry segment table, the segment bit-order constants and the polarity helper.
REQ-030 Hex-to-segment decode SHALL be the combinational sub-module decseg7 (4-bit in, 7-bit out), instantiated once on the selected nibble.

Verification
REQ-031 Use N_DIGITS=4, DIV=4 and ACTIVE_LOW=0 unless stated; check every scenario against a cycle-accurate model.
REQ-032 Scan: after reset, load data=16'h1234 and dp_in=0 -> an sequence 0001,0010,0100,1000 every 4 cycles; seg patterns for 4,3,2,1; frame pulses every 16 cycles.
REQ-033 Blanking: data=16'h0070 with blank_lz=1 -> digits 3 and 2 blanked; digit 1 pattern 0000111; digit 0 pattern 0111111.
REQ-034 DP override: data=16'h0005, dp_in=4'b0100, blank_lz=1 -> digit 2 shows 0111111 with dp=1; digit 3 blanked.
REQ-035 Mid-slot load: load 16'hFFFF at cycle 2 of digit 1's slot -> seg changes to 1110001 two cycles later; slot boundary unchanged.
REQ-036 Reset mid-scan with ACTIVE_LOW=1: assert rst during digit 2 -> an=4'b1111, seg=7'h7F, dp=1; after release, an=4'b1110 showing "0".
